// File: rtl/instr_fetch_queue_if.sv
// ============================================================================
//  Module   : instr_fetch_queue_if
//  Purpose  : Bundles the instruction-memory and decode-side signals of the fetch queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        inst_illegal;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect,
        input  redirect_addr,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready,
        output inst_illegal
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect,
        output redirect_addr,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready,
        input  inst_illegal
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Single-outstanding instruction fetcher feeding a DEPTH-entry FIFO.
//             Optional opcode check enabled by macro IFQ_OPCODE_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  wire                  clk,
    input  wire                  reset,
    instr_fetch_queue_if.master  bus
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_addr;
    logic [31:0]          w_addr_next;
    logic [31:0]          r_target;
    logic [31:0]          w_target_next;

    logic [31:0]          r_data_mem [DEPTH];
    logic [31:0]          r_pc_mem   [DEPTH];
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;

    logic                 w_valid;
    logic                 w_push;
    logic                 w_pop;
    logic [C_CNT_W-1:0]   w_count_after_pop;
    logic [C_CNT_W-1:0]   w_count_next;

    // Redirect overrides both push and pop in the same cycle.
    always_comb begin
        w_valid           = (r_count != '0);
        w_push            = (r_state == ST_WAIT) && bus.imem_rsp_valid && !bus.redirect;
        w_pop             = w_valid && bus.inst_ready && !bus.redirect;
        w_count_after_pop = r_count - C_CNT_W'(w_pop);
        w_count_next      = bus.redirect ? '0 : (w_count_after_pop + C_CNT_W'(w_push));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_addr   <= RESET_PC;
            r_target <= RESET_PC;
        end else begin
            r_state  <= w_state_next;
            r_addr   <= w_addr_next;
            r_target <= w_target_next;
        end
    end

    // r_addr is the address of the outstanding request (WAIT/DISCARD) or the
    // next address to fetch (RUN); in DISCARD the new target waits in r_target
    // so imem_addr stays stable until the stale response returns.
    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_target_next = r_target;
        case (r_state)
            ST_RUN: begin
                if (bus.redirect) begin
                    w_addr_next  = bus.redirect_addr;
                    w_state_next = ST_WAIT;
                end else if (w_count_after_pop < C_DEPTH) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.redirect) begin
                    if (bus.imem_rsp_valid) begin
                        w_addr_next  = bus.redirect_addr;
                        w_state_next = ST_RUN;
                    end else begin
                        w_target_next = bus.redirect_addr;
                        w_state_next  = ST_DISCARD;
                    end
                end else if (bus.imem_rsp_valid) begin
                    w_addr_next = r_addr + 32'd1;
                    if (w_count_next < C_DEPTH) begin
                        w_state_next = ST_WAIT;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_DISCARD: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.redirect) begin
                        w_addr_next  = bus.redirect_addr;
                        w_state_next = ST_RUN;
                    end else begin
                        w_addr_next  = r_target;
                        w_state_next = ST_WAIT;
                    end
                end else if (bus.redirect) begin
                    w_target_next = bus.redirect_addr;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (bus.redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(w_push);
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= bus.imem_rsp_data;
            r_pc_mem[r_wr_ptr]   <= r_addr;
        end
    end

    assign bus.imem_req   = (r_state != ST_RUN);
    assign bus.imem_addr  = r_addr;
    assign bus.inst_valid = w_valid;
    // Gate the head with valid so outputs read zero out of reset.
    assign bus.inst_data  = w_valid ? r_data_mem[r_rd_ptr] : 32'h0;
    assign bus.inst_pc    = w_valid ? r_pc_mem[r_rd_ptr]   : 32'h0;

`ifdef IFQ_OPCODE_CHECK_EN
    logic [6:0] w_opcode;
    assign w_opcode = bus.inst_data[6:0];
    assign bus.inst_illegal = w_valid &&
        !((w_opcode == 7'h33) || (w_opcode == 7'h03) ||
          (w_opcode == 7'h23) || (w_opcode == 7'h63));
`else
    assign bus.inst_illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Purpose  : Scoreboard bench for instr_fetch_queue with a latency-configurable memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        ill;
    } exp_t;

    logic clk;
    logic reset;
    logic reset_w;

    instr_fetch_queue_if bus();
    instr_fetch_queue_if w_bus();

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE)) u_wrap (
        .clk   (clk),
        .reset (reset_w),
        .bus   (w_bus.master)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   mem_lat = 0;
    int   wait_cnt = 0;
    int   rsp_cnt = 0;
    int   wrap_idx = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] wrap_exp [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0033;
        if (a == 32'h101) return 32'h0000_006F;
        return a;
    endfunction

    // Memory: answers after mem_lat cycles of an asserted request.
    always @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= 0;
        else if (!bus.imem_req || bus.imem_rsp_valid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    always @(posedge clk) begin
        if (reset && bus.imem_req && bus.imem_rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end
    assign bus.imem_rsp_valid = bus.imem_req && (wait_cnt >= mem_lat);
    assign bus.imem_rsp_data  = mem_word(bus.imem_addr);

    assign w_bus.imem_rsp_valid = w_bus.imem_req;
    assign w_bus.imem_rsp_data  = w_bus.imem_addr;
    assign w_bus.redirect       = 1'b0;
    assign w_bus.redirect_addr  = 32'h0;
    assign w_bus.inst_ready     = 1'b1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
        exp_t e;
        e.pc   = pc;
        e.data = data;
        e.ill  = 1'b0;
`ifdef IFQ_OPCODE_CHECK_EN
        e.ill  = !((data[6:0] == 7'h33) || (data[6:0] == 7'h03) ||
                   (data[6:0] == 7'h23) || (data[6:0] == 7'h63));
`endif
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.redirect = 1'b0;
        tick();
        tick();
        chk("rst_valid",   {31'b0, bus.inst_valid},   32'h0);
        chk("rst_req",     {31'b0, bus.imem_req},     32'h0);
        chk("rst_addr",    bus.imem_addr,             32'h0);
        chk("rst_data",    bus.inst_data,             32'h0);
        chk("rst_pc",      bus.inst_pc,               32'h0);
        chk("rst_illegal", {31'b0, bus.inst_illegal}, 32'h0);
    endtask

    task automatic drain(input string name, input int budget, output int cyc);
        cyc = 0;
        while (sb.size() != 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(name, 32'(sb.size()), 32'h0);
    endtask

    // Scoreboard monitor: a pop happens when valid&&ready and no redirect.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got pc %h data %h expected no output",
                             bus.inst_pc, bus.inst_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("inst_pc",      bus.inst_pc,               mon_e.pc);
                    chk("inst_data",    bus.inst_data,             mon_e.data);
                    chk("inst_illegal", {31'b0, bus.inst_illegal}, {31'b0, mon_e.ill});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_w && w_bus.inst_valid && w_bus.inst_ready && wrap_idx < 4) begin
                chk("wrap_pc",   w_bus.inst_pc,   wrap_exp[wrap_idx]);
                chk("wrap_data", w_bus.inst_data, wrap_exp[wrap_idx]);
                wrap_idx++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int base;
        int i;
        reset             = 1'b0;
        reset_w           = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 32'h0;
        bus.inst_ready    = 1'b0;
        mem_lat           = 0;

        // Zero-latency streaming, one instruction per cycle.
        apply_reset();
        chk("wrap_rst_addr",  w_bus.imem_addr,             32'hFFFF_FFFE);
        chk("wrap_rst_valid", {31'b0, w_bus.inst_valid},   32'h0);
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 16; k++) push_exp(32'(k), 32'(k));
        reset = 1'b1;
        drain("a_drain", 40, cyc);
        n_tests++;
        if (cyc > 20) begin
            n_fail++;
            $display("FAIL a_throughput: got %0d cycles expected at most 20", cyc);
        end
        bus.inst_ready = 1'b0;

        // Fill with decode stalled, then release.
        apply_reset();
        base = rsp_cnt;
        reset = 1'b1;
        repeat (12) tick();
        chk("b_rsp_count", 32'(rsp_cnt - base),          32'd4);
        chk("b_req_low",   {31'b0, bus.imem_req},        32'h0);
        chk("b_valid",     {31'b0, bus.inst_valid},      32'h1);
        chk("b_head_pc",   bus.inst_pc,                  32'h0);
        for (int k = 0; k < 8; k++) push_exp(32'(k), 32'(k));
        bus.inst_ready = 1'b1;
        drain("b_drain", 60, cyc);
        bus.inst_ready = 1'b0;

        // Latency 3, redirect during the second wait cycle.
        mem_lat = 3;
        apply_reset();
        bus.inst_ready = 1'b1;
        reset = 1'b1;
        i = 0;
        do begin
            tick();
            i++;
        end while (!bus.imem_req && i < 10);
        chk("c_req_seen", {31'b0, bus.imem_req}, 32'h1);
        tick();
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h40;
        sb.delete();
        for (int k = 0; k < 4; k++) push_exp(32'h40 + 32'(k), 32'h40 + 32'(k));
        tick();
        bus.redirect = 1'b0;
        chk("c_hold_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("c_hold_addr", bus.imem_addr,         32'h0);
        drain("c_drain", 80, cyc);
        bus.inst_ready = 1'b0;

        // Reset while a request is outstanding.
        apply_reset();
        reset = 1'b1;
        tick();
        tick();
        chk("g_req_before", {31'b0, bus.imem_req}, 32'h1);
        reset = 1'b0;
        tick();
        chk("g_req_reset",   {31'b0, bus.imem_req},   32'h0);
        chk("g_valid_reset", {31'b0, bus.inst_valid}, 32'h0);
        for (int k = 0; k < 3; k++) push_exp(32'(k), 32'(k));
        reset = 1'b1;
        bus.inst_ready = 1'b1;
        drain("g_drain", 60, cyc);
        bus.inst_ready = 1'b0;

        // Redirect coinciding with a response and a pop.
        mem_lat = 0;
        apply_reset();
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(32'(k), 32'(k));
        reset = 1'b1;
        drain("d_pre_drain", 30, cyc);
        chk("d_pre_valid", {31'b0, bus.inst_valid},     32'h1);
        chk("d_pre_rsp",   {31'b0, bus.imem_rsp_valid}, 32'h1);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h10;
        sb.delete();
        for (int k = 0; k < 4; k++) push_exp(32'h10 + 32'(k), 32'h10 + 32'(k));
        tick();
        bus.redirect = 1'b0;
        chk("d_flush_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("d_next_addr",   bus.imem_addr,           32'h10);
        drain("d_drain", 40, cyc);
        bus.inst_ready = 1'b0;

        // Opcode words 0x33 and 0x6F.
        apply_reset();
        reset = 1'b1;
        tick();
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h100;
        sb.delete();
        push_exp(32'h100, 32'h0000_0033);
        push_exp(32'h101, 32'h0000_006F);
        push_exp(32'h102, 32'h0000_0102);
        push_exp(32'h103, 32'h0000_0103);
        tick();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b1;
        drain("e_drain", 40, cyc);
        bus.inst_ready = 1'b0;

        // PC wrap from RESET_PC = FFFFFFFE.
        reset_w = 1'b1;
        repeat (12) tick();
        chk("f_wrap_count", 32'(wrap_idx), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, FIFO entries (power of 2, 2..16); RESET_PC, 32'h0, first fetch word address.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset (reset==0 resets; deassertion sampled on clk).
REQ-004 imem_req  output  1  fetch request to instruction memory, held until response.
REQ-005 imem_addr  output  32  word address of the outstanding request.
REQ-006 imem_rsp_valid  input  1  response valid; may be high in the same cycle as imem_req.
REQ-007 imem_rsp_data  input  32  instruction word returned.
REQ-008 redirect  input  1  branch taken: flush and refetch (driven from pc_sel).
REQ-009 redirect_addr  input  32  new fetch word address (from jmp_addr).
REQ-010 inst_valid  output  1  FIFO head valid toward decode.
REQ-011 inst_data  output  32  FIFO head instruction.
REQ-012 inst_pc  output  32  word address of FIFO head.
REQ-013 inst_ready  input  1  decode accepts head when inst_valid&&inst_ready.
REQ-014 inst_illegal  output  1  head opcode unsupported (see Configuration).

Function
REQ-015 Fetch PC SHALL be word-addressed, advancing by 1 per accepted response, wrapping 32'hFFFFFFFF->0.
REQ-016 At most one request SHALL be outstanding; imem_addr SHALL stay stable while imem_req high and imem_rsp_valid low.
REQ-017 A new request SHALL be issued only when count + outstanding < DEPTH; FIFO SHALL never overflow.
REQ-018 FSM states: RUN (no outstanding), WAIT (request outstanding), DISCARD (outstanding request invalidated).
REQ-019 RUN->WAIT when space permits; WAIT->WAIT on response with space for a back-to-back request (throughput 1/cycle with zero-latency memory); WAIT->RUN on response without space.
REQ-020 Response accepted in WAIT SHALL be written with its address at that edge; inst_valid SHALL be high from that edge (inst_valid == count!=0).
REQ-021 Simultaneous push and pop SHALL keep count unchanged; pop on empty SHALL be ignored.
REQ-022 redirect SHALL, at that edge, empty the FIFO, set fetch PC to redirect_addr, and take precedence over same-cycle push and pop.
REQ-023 redirect in WAIT without same-cycle response SHALL go to DISCARD; the next response SHALL be dropped, then request redirect_addr.
REQ-024 redirect in WAIT with same-cycle response SHALL drop that response and go to RUN.
REQ-025 redirect in DISCARD SHALL update the target address and remain in DISCARD.
REQ-026 inst_data/inst_pc SHALL be don't-care while inst_valid is low.

Reset
REQ-027 While reset==0: state RUN, fetch PC=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, inst_illegal=0.
REQ-028 First imem_req SHALL assert on the first edge after reset deassertion; reset mid-request SHALL abandon it with no response consumed afterward.

Configuration
REQ-029 Macro IFQ_OPCODE_CHECK_EN defined: inst_illegal=1 when inst_valid and inst_data[6:0] not in {7'h33,7'h03,7'h23,7'h63}.
REQ-030 Macro IFQ_OPCODE_CHECK_EN undefined: inst_illegal tied 0, no check logic.

Verification
REQ-031 Reset release, zero-latency memory returning word==address, inst_ready=1 -> inst_pc 0,1,2,3... one per cycle, inst_data equal.
REQ-032 inst_ready=0, DEPTH=4 -> exactly 4 entries fill, imem_req low thereafter; ready=1 -> PCs 0..3 in order, fetch resumes at 4.
REQ-033 Memory latency 3 cycles, redirect to 32'h40 in the 2nd wait cycle -> stale response dropped, next inst_pc=32'h40.
REQ-034 redirect to 32'h10 same cycle as response and pop -> FIFO empty next cycle, next request addr 32'h10, no stale head.
REQ-035 RESET_PC=32'hFFFFFFFE -> inst_pc sequence FFFFFFFE, FFFFFFFF, 0, 1.
REQ-036 With IFQ_OPCODE_CHECK_EN, words 32'h00000033 then 32'h0000006F -> inst_illegal 0 then 1; without macro always 0.
